pwm_duty_meter: RTL and testbench

- Downstream consumer of the PWM generator output.
- Synchronises the incoming PWM waveform and measures high time and period in clk1ms cycles.
- Publishes each completed measurement with a one-cycle valid strobe.
- Flags a stuck-high or stuck-low input, e.g. 0 % or 100 % duty or a dead generator, so the supervisory logic can check that the generator is running.

---
 rtl/pwm_meas_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 37 +++
 rtl/pwm_duty_meter.sv | 144 ++++++++++++++
 tb/tb_pwm_duty_meter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_meas_pkg
// Brief    : Shared constants for the PWM duty-cycle meter (state codes, widths).
// Revision : 1.0 - initial release
// ============================================================================
package pwm_meas_pkg;

    localparam int CNT_W_DEFAULT = 26;
    localparam int STATE_W       = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
    localparam logic [STATE_W-1:0] ST_HIGH = 2'b01;
    localparam logic [STATE_W-1:0] ST_LOW  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : Two-flop synchroniser plus edge register; emits level, rise, fall.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_det (
    input  logic clk1ms,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk1ms or posedge reset) begin
        if (reset) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= async_in;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_sync_d;
    assign fall  = ~r_sync & r_sync_d;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_meter.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_meter
// Brief    : Measures PWM high time and period in clock cycles; flags stuck input.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_meter
    import pwm_meas_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(50_000_000)
) (
    input  logic               clk1ms,
    input  logic               reset,
    input  logic               pwm_in,
    output logic [CNT_W-1:0]   high_cnt,
    output logic [CNT_W-1:0]   period_cnt,
    output logic               meas_valid,
    output logic               stuck_high,
    output logic               stuck_low,
    output logic [STATE_W-1:0] state
);

    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_limit = TIMEOUT - c_one;

    logic w_level;
    logic w_rise;
    logic w_fall;

    sync_edge_det u_sync (
        .clk1ms   (clk1ms),
        .reset    (reset),
        .async_in (pwm_in),
        .level    (w_level),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    logic [STATE_W-1:0] r_state, w_state_n;
    logic [CNT_W-1:0]   r_hi_run, w_hi_run_n;
    logic [CNT_W-1:0]   r_per_run, w_per_run_n;
    logic [CNT_W-1:0]   r_high_cnt, w_high_cnt_n;
    logic [CNT_W-1:0]   r_period_cnt, w_period_cnt_n;
    logic               r_meas_valid, w_meas_valid_n;
    logic               r_stuck_high, w_stuck_high_n;
    logic               r_stuck_low, w_stuck_low_n;

    logic [CNT_W-1:0] w_hi_inc;
    logic [CNT_W-1:0] w_per_inc;
    logic             w_at_limit;

    // Saturating increments: counters never wrap past TIMEOUT.
    assign w_hi_inc   = (r_hi_run  >= TIMEOUT) ? TIMEOUT : r_hi_run  + c_one;
    assign w_per_inc  = (r_per_run >= TIMEOUT) ? TIMEOUT : r_per_run + c_one;
    assign w_at_limit = (r_per_run >= c_limit);

    always_ff @(posedge clk1ms or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_hi_run     <= '0;
            r_per_run    <= '0;
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
            r_meas_valid <= 1'b0;
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_hi_run     <= w_hi_run_n;
            r_per_run    <= w_per_run_n;
            r_high_cnt   <= w_high_cnt_n;
            r_period_cnt <= w_period_cnt_n;
            r_meas_valid <= w_meas_valid_n;
            r_stuck_high <= w_stuck_high_n;
            r_stuck_low  <= w_stuck_low_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_hi_run_n     = r_hi_run;
        w_per_run_n    = r_per_run;
        w_high_cnt_n   = r_high_cnt;
        w_period_cnt_n = r_period_cnt;
        w_meas_valid_n = 1'b0;
        w_stuck_high_n = r_stuck_high;
        w_stuck_low_n  = r_stuck_low;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_hi_run_n  = c_one;
                    w_per_run_n = c_one;
                    w_state_n   = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_per_run_n = w_per_inc;
                    w_state_n   = ST_LOW;
                end else if (w_at_limit) begin
                    w_stuck_high_n = r_stuck_high | w_level;
                    w_stuck_low_n  = r_stuck_low  | ~w_level;
                    w_state_n      = ST_IDLE;
                end else begin
                    w_hi_run_n  = w_hi_inc;
                    w_per_run_n = w_per_inc;
                end
            end
            ST_LOW: begin
                // A rise arriving together with the timeout still completes the period.
                if (w_rise) begin
                    w_high_cnt_n   = r_hi_run;
                    w_period_cnt_n = r_per_run;
                    w_meas_valid_n = 1'b1;
                    w_stuck_high_n = 1'b0;
                    w_stuck_low_n  = 1'b0;
                    w_hi_run_n     = c_one;
                    w_per_run_n    = c_one;
                    w_state_n      = ST_HIGH;
                end else if (w_at_limit) begin
                    w_stuck_high_n = r_stuck_high | w_level;
                    w_stuck_low_n  = r_stuck_low  | ~w_level;
                    w_state_n      = ST_IDLE;
                end else begin
                    w_per_run_n = w_per_inc;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign high_cnt   = r_high_cnt;
    assign period_cnt = r_period_cnt;
    assign meas_valid = r_meas_valid;
    assign stuck_high = r_stuck_high;
    assign stuck_low  = r_stuck_low;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_meter
// Brief    : Self-checking bench for pwm_duty_meter against a period-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_meter;

    localparam int          CNT_W   = 26;
    localparam logic [25:0] TIMEOUT = 26'd16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;
    logic [1:0]       state;

    pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk1ms     (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct { int h; int p; bit contig; } exp_t;
    typedef struct { int h; int p; int cyc; } obs_t;
    exp_t exp_q[$];
    obs_t obs_q[$];

    // Period-level model: a measurement of the previous period is due at every rise.
    int pend_h, pend_p, last_h, last_p;
    bit have_pend = 0;
    bit chain     = 0;

    int  wide_pulses   = 0;
    int  strobe_stuck  = 0;
    logic prev_valid   = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset && meas_valid) begin
            obs_t o;
            o.h = int'(high_cnt);
            o.p = int'(period_cnt);
            o.cyc = cyc;
            obs_q.push_back(o);
            if (prev_valid) wide_pulses++;
            if (stuck_high || stuck_low) strobe_stuck++;
        end
        prev_valid = meas_valid;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_rise();
        exp_t e;
        if (have_pend) begin
            e.h = pend_h;
            e.p = pend_p;
            e.contig = chain;
            exp_q.push_back(e);
            last_h = pend_h;
            last_p = pend_p;
            chain  = 1;
        end
        have_pend = 0;
    endfunction

    function automatic void model_idle();
        have_pend = 0;
        chain     = 0;
    endfunction

    task automatic period(input int h, input int l);
        model_rise();
        pend_h = h;
        pend_p = h + l;
        have_pend = 1;
        pwm_in = 1'b1;
        tick(h);
        pwm_in = 1'b0;
        tick(l);
    endtask

    task automatic check_meas(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_high"}, obs_q[i].h, exp_q[i].h);
            chk({tag, "_period"}, obs_q[i].p, exp_q[i].p);
            if (i > 0 && exp_q[i].contig)
                chk({tag, "_spacing"}, obs_q[i].cyc - obs_q[i-1].cyc, exp_q[i].p);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_high_cnt"}, high_cnt, 0);
        chk({tag, "_period_cnt"}, period_cnt, 0);
        chk({tag, "_meas_valid"}, meas_valid, 0);
        chk({tag, "_stuck_high"}, stuck_high, 0);
        chk({tag, "_stuck_low"}, stuck_low, 0);
        chk({tag, "_state"}, state, 2'b00);
    endtask

    initial begin
        // Reset held while the pin toggles.
        tick(1);
        for (int i = 0; i < 10; i++) begin
            pwm_in = ~pwm_in;
            tick(1);
        end
        check_cleared("reset_hold");
        pwm_in = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);

        // First rise: HIGH state, no measurement yet.
        pend_h = 3;
        pend_p = 8;
        have_pend = 1;
        pwm_in = 1'b1;
        tick(3);
        chk("first_rise_state", state, 2'b01);
        chk("first_rise_no_meas", obs_q.size(), 0);
        pwm_in = 1'b0;
        tick(5);

        // Steady H=3 L=5, minimum pulse, change to H=6 L=2, random periods.
        for (int i = 0; i < 3; i++) period(3, 5);
        for (int i = 0; i < 3; i++) period(1, 2);
        for (int i = 0; i < 2; i++) period(6, 2);
        for (int i = 0; i < 8; i++) period($urandom_range(6, 1), $urandom_range(6, 1));

        // Stuck high: rise closes the last period, then the pin stays high.
        model_rise();
        model_idle();
        pwm_in = 1'b1;
        tick(17);
        chk("sh_pre_flag", stuck_high, 0);
        chk("sh_pre_state", state, 2'b01);
        tick(1);
        chk("sh_flag", stuck_high, 1);
        chk("sh_low_flag", stuck_low, 0);
        chk("sh_state", state, 2'b00);
        chk("sh_hold_high", high_cnt, last_h);
        chk("sh_hold_period", period_cnt, last_p);
        tick(5);
        chk("sh_no_valid", meas_valid, 0);
        check_meas("run1");

        // Recovery with H=4 L=4; flag is sticky until the first measurement.
        pwm_in = 1'b0;
        tick(4);
        chk("sh_sticky", stuck_high, 1);
        period(4, 4);
        period(4, 4);

        // Stuck low: H=2 then low forever.
        model_rise();
        model_idle();
        pwm_in = 1'b1;
        tick(2);
        pwm_in = 1'b0;
        tick(15);
        chk("sl_pre_flag", stuck_low, 0);
        chk("sl_high_cleared", stuck_high, 0);
        tick(1);
        chk("sl_flag", stuck_low, 1);
        chk("sl_high_flag", stuck_high, 0);
        chk("sl_state", state, 2'b00);
        tick(3);
        check_meas("run2");

        // Reset two cycles into LOW.
        pwm_in = 1'b1;
        tick(3);
        pwm_in = 1'b0;
        tick(5);
        chk("mid_state_low", state, 2'b10);
        #2 reset = 1'b1;
        #1 check_cleared("reset_mid");
        tick(2);
        reset = 1'b0;
        model_idle();
        tick(2);
        for (int i = 0; i < 3; i++) period(2, 3);
        model_rise();
        pwm_in = 1'b1;
        tick(6);
        check_meas("run3");

        chk("pulse_width", wide_pulses, 0);
        chk("strobe_flags_clear", strobe_stuck, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
